// File: rtl/data_sram_slave_pkg.sv
// Shared definitions for the data SRAM slave: access-size encodings and lane-strobe width.
package data_sram_slave_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE    = 2'd0,
        SZ_HALF    = 2'd1,
        SZ_WORD    = 2'd2,
        SZ_ILLEGAL = 2'd3
    } size_e;

    localparam int STRB_W = 4;

endpackage

// File: rtl/data_sram_slave_lane_mask.sv
// Decodes access size and low address bits into a byte-lane write strobe
// and a misalignment/illegal-size error flag.
module dsram_lane_mask
    import data_sram_slave_pkg::*;
(
    input  logic [1:0]        size,
    input  logic [1:0]        addr_lo,
    output logic [STRB_W-1:0] strb,
    output logic              err
);

    always_comb begin
        strb = '0;
        err  = 1'b0;
        case (size_e'(size))
            SZ_BYTE: strb = 4'b0001 << addr_lo;
            SZ_HALF: begin
                if (addr_lo[0]) err = 1'b1;
                else            strb = addr_lo[1] ? 4'b1100 : 4'b0011;
            end
            SZ_WORD: begin
                if (addr_lo != 2'd0) err = 1'b1;
                else                 strb = {STRB_W{1'b1}};
            end
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/data_sram_slave.sv
// Data SRAM slave for the memory stage: addr_ok/data_ok handshake, fixed response
// latency, bounded outstanding requests, byte-lane stores and wrap-around indexing.
module data_sram_slave
    import data_sram_slave_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2,
    parameter int MAXOUT  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata,
    output logic        err
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(MAXOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAXOUT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               accept;
    logic               mem_we;
    logic [STRB_W-1:0]  strb;
    logic               lane_err;
    logic [IDX_W-1:0]   idx;
    logic               unused_addr_hi;

    logic [31:0]        mem_q [DEPTH];

    logic [LATENCY-1:0] vld_q, vld_d;
    logic [LATENCY-1:0] err_q, err_d;
    logic [31:0]        rdata_q [LATENCY];
    logic [31:0]        rdata_d [LATENCY];

    dsram_lane_mask u_lane_mask (
        .size    (size),
        .addr_lo (addr[1:0]),
        .strb    (strb),
        .err     (lane_err)
    );

    // Address bits above the array index are deliberately ignored (wrap-around).
    assign idx            = addr[IDX_W+1:2];
    assign unused_addr_hi = ^addr[31:IDX_W+2];

    assign addr_ok = (cnt_q < CNT_MAX);
    assign accept  = req && addr_ok;
    assign mem_we  = accept && wr && !lane_err;

    assign data_ok = vld_q[LATENCY-1];
    assign err     = err_q[LATENCY-1];
    assign rdata   = rdata_q[LATENCY-1];

    always_comb begin
        cnt_d = cnt_q;
        if (accept && !data_ok)      cnt_d = cnt_q + CNT_ONE;
        else if (!accept && data_ok) cnt_d = cnt_q - CNT_ONE;
    end

    // Stage 0 captures the response at the accepting edge; later stages only shift.
    always_comb begin
        vld_d = '0;
        err_d = '0;
        for (int i = 0; i < LATENCY; i++) rdata_d[i] = '0;
        vld_d[0]   = accept;
        err_d[0]   = accept && lane_err;
        rdata_d[0] = (accept && !wr && !lane_err) ? mem_q[idx] : 32'h0;
        for (int i = 1; i < LATENCY; i++) begin
            vld_d[i]   = vld_q[i-1];
            err_d[i]   = err_q[i-1];
            rdata_d[i] = rdata_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            vld_q <= '0;
            err_q <= '0;
            for (int i = 0; i < LATENCY; i++) rdata_q[i] <= '0;
        end else begin
            cnt_q <= cnt_d;
            vld_q <= vld_d;
            err_q <= err_d;
            for (int i = 0; i < LATENCY; i++) rdata_q[i] <= rdata_d[i];
        end
    end

    // Array contents survive reset; only the selected byte lanes are written.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (strb[b]) mem_q[idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_data_sram_slave.sv
// Directed bench for data_sram_slave: one default instance (LATENCY=2) and one with LATENCY=3.
module tb_data_sram_slave;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_a, req_b, wr;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    logic        addr_ok_a, data_ok_a, err_a;
    logic [31:0] rdata_a;
    logic        addr_ok_b, data_ok_b, err_b;
    logic [31:0] rdata_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    data_sram_slave #(.DEPTH(256), .LATENCY(2), .MAXOUT(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .req(req_a), .wr(wr), .size(size), .addr(addr),
        .wdata(wdata), .addr_ok(addr_ok_a), .data_ok(data_ok_a), .rdata(rdata_a), .err(err_a)
    );

    data_sram_slave #(.DEPTH(256), .LATENCY(3), .MAXOUT(2)) u_dut_l3 (
        .clk(clk), .rst_n(rst_n), .req(req_b), .wr(wr), .size(size), .addr(addr),
        .wdata(wdata), .addr_ok(addr_ok_b), .data_ok(data_ok_b), .rdata(rdata_b), .err(err_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One request on the selected instance, then wait (bounded) for its response.
    task automatic xact(input bit use_b, input logic w, input logic [1:0] sz,
                        input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic er, output int lat);
        @(negedge clk);
        wr = w; size = sz; addr = a; wdata = d;
        if (use_b) req_b = 1'b1;
        else       req_a = 1'b1;
        @(posedge clk);
        #1;
        req_a = 1'b0; req_b = 1'b0; wr = 1'b0; size = 2'd0; addr = '0; wdata = '0;
        lat = 0; rd = '0; er = 1'b0;
        while (lat < 10) begin
            @(negedge clk);
            lat++;
            if (use_b ? data_ok_b : data_ok_a) begin
                rd = use_b ? rdata_b : rdata_a;
                er = use_b ? err_b : err_a;
                break;
            end
        end
    endtask

    task automatic do_chk(input string tag, input bit use_b, input logic w, input logic [1:0] sz,
                          input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
        logic [31:0] rd;
        logic        er;
        int          lat;
        xact(use_b, w, sz, a, d, rd, er, lat);
        check({tag, ".lat"}, lat, exp_lat);
        check({tag, ".rdata"}, rd, exp_rd);
        check({tag, ".err"}, {31'h0, er}, {31'h0, exp_err});
    endtask

    function automatic logic [31:0] burst_val(input int i);
        return 32'hB0B0_0000 + i;
    endfunction

    initial begin
        int acc, resp, first_stall, first_dok, pulses;

        rst_n = 1'b0; req_a = 1'b0; req_b = 1'b0; wr = 1'b0;
        size = 2'd0; addr = '0; wdata = '0;

        @(negedge clk);
        check("reset.addr_ok", addr_ok_a, 1);
        check("reset.data_ok", data_ok_a, 0);
        check("reset.rdata", rdata_a, 0);
        check("reset.err", err_a, 0);
        check("reset.addr_ok_l3", addr_ok_b, 1);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic store then load
        do_chk("st_word10", 0, 1'b1, 2'd2, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2);
        do_chk("ld_word10", 0, 1'b0, 2'd2, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2);

        // Byte and halfword lane merges
        do_chk("st_word20", 0, 1'b1, 2'd2, 32'h20, 32'h11223344, 32'h0, 1'b0, 2);
        do_chk("st_byte21", 0, 1'b1, 2'd0, 32'h21, 32'h0000AA00, 32'h0, 1'b0, 2);
        do_chk("ld_merge1", 0, 1'b0, 2'd2, 32'h20, 32'h0, 32'h1122AA44, 1'b0, 2);
        do_chk("st_half22", 0, 1'b1, 2'd1, 32'h22, 32'h55660000, 32'h0, 1'b0, 2);
        do_chk("ld_merge2", 0, 1'b0, 2'd2, 32'h20, 32'h0, 32'h5566AA44, 1'b0, 2);

        // Error requests: no write, err=1, rdata=0
        do_chk("ld_mis_w22", 0, 1'b0, 2'd2, 32'h22, 32'h0, 32'h0, 1'b1, 2);
        do_chk("st_size3", 0, 1'b1, 2'd3, 32'h20, 32'hFFFFFFFF, 32'h0, 1'b1, 2);
        do_chk("st_mis_h23", 0, 1'b1, 2'd1, 32'h23, 32'hFFFFFFFF, 32'h0, 1'b1, 2);
        do_chk("ld_after_err", 0, 1'b0, 2'd2, 32'h20, 32'h0, 32'h5566AA44, 1'b0, 2);

        // Wrap-around: 0x400 aliases word 0 with 256 words
        do_chk("st_wrap400", 0, 1'b1, 2'd2, 32'h400, 32'hCAFEF00D, 32'h0, 1'b0, 2);
        do_chk("ld_wrap000", 0, 1'b0, 2'd2, 32'h000, 32'h0, 32'hCAFEF00D, 1'b0, 2);

        // Inputs without req must be ignored
        @(negedge clk);
        wr = 1'b1; size = 2'd2; addr = 32'h10; wdata = 32'h0;
        @(negedge clk);
        wr = 1'b0;
        do_chk("ld_no_req_wr", 0, 1'b0, 2'd2, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2);

        // Preload LATENCY=3 instance, then burst with req held high
        for (int i = 0; i < 6; i++)
            do_chk($sformatf("l3_st%0d", i), 1, 1'b1, 2'd2, 32'(4 * i), burst_val(i), 32'h0, 1'b0, 3);

        acc = 0; resp = 0; first_stall = -1; first_dok = -1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (data_ok_b) begin
                if (resp < 6) check($sformatf("burst.rd%0d", resp), rdata_b, burst_val(resp));
                if (first_dok < 0) first_dok = c;
                resp++;
            end
            if (first_dok >= 0 && c == first_dok + 1) check("burst.ok_after_dok", addr_ok_b, 1);
            if (acc < 6) begin
                req_b = 1'b1; wr = 1'b0; size = 2'd2; addr = 32'(4 * acc);
                if (addr_ok_b) acc++;
                else if (first_stall < 0) first_stall = c;
            end else begin
                req_b = 1'b0;
            end
        end
        req_b = 1'b0;
        check("burst.first_stall", first_stall, 2);
        check("burst.first_dok", first_dok, 3);
        check("burst.accepts", acc, 6);
        check("burst.responses", resp, 6);

        // Reset with two requests in flight
        @(negedge clk);
        wr = 1'b0; size = 2'd2; addr = 32'h10; req_a = 1'b1;
        check("rst.ok_first", addr_ok_a, 1);
        @(negedge clk);
        addr = 32'h20;
        check("rst.ok_second", addr_ok_a, 1);
        @(posedge clk);
        #1;
        req_a = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check("rst.mid_addr_ok", addr_ok_a, 1);
        check("rst.mid_data_ok", data_ok_a, 0);
        check("rst.mid_rdata", rdata_a, 0);
        check("rst.mid_err", err_a, 0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        repeat (6) begin
            @(negedge clk);
            if (data_ok_a) pulses++;
        end
        check("rst.no_stale_resp", pulses, 0);
        check("rst.addr_ok_after", addr_ok_a, 1);
        do_chk("rst.ld_retained", 0, 1'b0, 2'd2, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/data_sram_slave.md
DATA_SRAM_SLAVE -- requirements
Module: data_sram_slave

Interface
REQ-001 SHALL have parameter DEPTH, default 256, meaning data array size in 32-bit words (power of two, 16..4096).
REQ-002 SHALL have parameter LATENCY, default 2, meaning cycles from request acceptance to data_ok (1..4).
REQ-003 SHALL have parameter MAXOUT, default 2, meaning maximum outstanding accepted-but-unanswered requests (1..4).
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port req  input  1  request valid from the memory-stage master.
REQ-007 SHALL have port wr  input  1  1 = store, 0 = load.
REQ-008 SHALL have port size  input  2  0 byte, 1 halfword, 2 word, 3 illegal.
REQ-009 SHALL have port addr  input  32  byte address.
REQ-010 SHALL have port wdata  input  32  store data, lane-aligned to addr[1:0].
REQ-011 SHALL have port addr_ok  output  1  request accepted this cycle when req && addr_ok.
REQ-012 SHALL have port data_ok  output  1  one-cycle response pulse, one per accepted request.
REQ-013 SHALL have port rdata  output  32  full aligned word for loads, valid only with data_ok.
REQ-014 SHALL have port err  output  1  response error flag, valid only with data_ok.

Function
REQ-015 SHALL assert addr_ok combinationally when outstanding count < MAXOUT, independent of req.
REQ-016 SHALL increment the outstanding count on accept, decrement it on data_ok, and leave it unchanged when both occur in the same cycle.
REQ-017 SHALL pulse data_ok exactly LATENCY cycles after the accepting edge, responses in acceptance order, at most one per cycle.
REQ-018 SHALL index the array with addr[log2(DEPTH)+1:2]; higher address bits are ignored (wrap-around).
REQ-019 SHALL flag as error: size 3; size 1 with addr[0]=1; size 2 with addr[1:0]!=0.
REQ-020 SHALL, for a non-error store, write at the accepting edge only the byte lanes selected by size/addr[1:0] (byte: lane addr[1:0]; half: lanes {addr[1],0} and {addr[1],1}; word: all four).
REQ-021 SHALL, for a non-error load, capture the array word at the accepting edge, so a store accepted in an earlier cycle is visible to it.
REQ-022 SHALL, for an error request, perform no write and respond with err=1, rdata=0.
REQ-023 SHALL drive rdata=0 for store responses and rdata=0, err=0 whenever data_ok=0.
REQ-024 SHALL ignore wr, size, addr and wdata in cycles where req && addr_ok is false.

Reset
REQ-025 SHALL, on rst_n low, immediately clear outstanding count, all in-flight response slots, data_ok, err and rdata; addr_ok reads 1 after reset.
REQ-026 SHALL discard in-flight responses when reset asserts mid-operation; they are never delivered.
REQ-027 SHALL NOT reset the data array contents.

Structure
REQ-028 SHALL place size encodings (byte/half/word) and the lane-strobe width constant in the shared defines file used by the pipeline stages.
REQ-029 SHALL implement the response delay as a LATENCY-deep valid/err/rdata shift pipeline; one sub-module is natural: dsram_lane_mask (size + addr[1:0] -> 4-bit strobe and error flag).

Verification
REQ-030 SHALL cover: store word 0xDEADBEEF @0x10, then load @0x10 -> data_ok two cycles after each accept, second rdata=0xDEADBEEF, err=0.
REQ-031 SHALL cover: word 0x11223344 @0x20, store byte 0xAA in lane 1 (addr 0x21), load @0x20 -> rdata=0x1122AA44.
REQ-032 SHALL cover: req held high for 6 cycles with LATENCY=3, MAXOUT=2 -> addr_ok drops after 2 accepts, reasserts on first data_ok, exactly 6 in-order data_ok pulses total.
REQ-033 SHALL cover: load size 2 @0x22 and a store of size 3 -> err=1, rdata=0, no array word changes.
REQ-034 SHALL cover: rst_n pulsed low while 2 requests in flight -> no data_ok afterwards, addr_ok=1, array retains earlier stored data.
REQ-035 SHALL cover: DEPTH=256 store word @0x400 then load @0x000 -> rdata equals stored value (wrap-around).
